// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter: control/data inputs and count/status outputs.
// The master side (consumer or bench) drives the controls; the slave side is the counter.
interface param_updown_counter_if #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) ();
    logic                  clear;
    logic                  load;
    logic [WIDTH-1:0]      d;
    logic                  en;
    logic                  up_down;
    logic [STEP_WIDTH-1:0] step;
    logic [WIDTH-1:0]      q;
    logic                  wrap;
    logic                  sat;
    logic                  at_max;
    logic                  at_zero;

    modport master (
        output clear, load, d, en, up_down, step,
        input  q, wrap, sat, at_max, at_zero
    );

    modport slave (
        input  clear, load, d, en, up_down, step,
        output q, wrap, sat, at_max, at_zero
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus, variable step,
// wrap-or-saturate boundary handling and boundary status outputs.
// Update priority: reset > clear > load > count enable > hold.
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = 255,
    parameter bit SATURATE   = 1'b0,
    parameter int STEP_WIDTH = 4,
    parameter int RESET_VAL  = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    param_updown_counter_if.slave bus
);

    // One extra bit over the wider of count/step so q + s and q + (MAX_VAL+1)
    // never overflow the intermediate arithmetic.
    localparam int AW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;
    localparam logic [AW-1:0]    MAX_EXT   = AW'(MAX_VAL);
    localparam logic [AW-1:0]    MOD_EXT   = AW'(MAX_VAL) + AW'(1);
    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             sat_r;

    logic [AW-1:0]    q_ext;
    logic [AW-1:0]    step_ext;
    logic [AW-1:0]    s_eff;
    logic [AW-1:0]    d_ext;
    logic [AW-1:0]    up_sum;

    logic [WIDTH-1:0] load_val;
    logic             load_clamp;
    logic [WIDTH-1:0] count_val;
    logic             count_wrap;
    logic             count_sat;

    // Widen operands, clamp the step to the modulus and clamp the load value.
    always_comb begin
        q_ext      = AW'(q_r);
        step_ext   = AW'(bus.step);
        d_ext      = AW'(bus.d);
        s_eff      = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        up_sum     = q_ext + s_eff;
        load_clamp = (d_ext > MAX_EXT);
        load_val   = load_clamp ? MAX_Q : bus.d;
    end

    // Next count for an enabled cycle, with boundary wrap or clamp.
    always_comb begin
        count_val  = q_r;
        count_wrap = 1'b0;
        count_sat  = 1'b0;
        if (bus.up_down) begin
            if (up_sum <= MAX_EXT) begin
                count_val = WIDTH'(up_sum);
            end else if (SATURATE) begin
                count_val = MAX_Q;
                count_sat = 1'b1;
            end else begin
                count_val  = WIDTH'(up_sum - MOD_EXT);
                count_wrap = 1'b1;
            end
        end else begin
            if (s_eff <= q_ext) begin
                count_val = WIDTH'(q_ext - s_eff);
            end else if (SATURATE) begin
                count_val = '0;
                count_sat = 1'b1;
            end else begin
                count_val  = WIDTH'(q_ext + MOD_EXT - s_eff);
                count_wrap = 1'b1;
            end
        end
    end

    // Count register and one-cycle status pulses, applied in priority order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r    <= RESET_Q;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else if (bus.clear) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else if (bus.load) begin
            q_r    <= load_val;
            wrap_r <= 1'b0;
            sat_r  <= load_clamp;
        end else if (bus.en) begin
            q_r    <= count_val;
            wrap_r <= count_wrap;
            sat_r  <= count_sat;
        end else begin
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end
    end

    // Outputs: registered count and pulses, combinational boundary flags.
    always_comb begin
        bus.q       = q_r;
        bus.wrap    = wrap_r;
        bus.sat     = sat_r;
        bus.at_max  = (q_r == MAX_Q);
        bus.at_zero = (q_r == '0);
    end

endmodule
